gnss_search_scheduler: RTL and testbench
========================================

# gnss_search_scheduler

Sequences the GNSS acquisition engine across a programmable set of satellites. It walks a 32-bit SV mask, and for each enabled SV it drives the engine's start/SV inputs and waits for the fine search to finish or time out. It then captures Doppler, code phase and correlation, compares the correlation against a threshold, and presents one result record per SV on a valid/ready stream. It sits between the AHB register satellite (control/status) and the coarse/fine search datapath.

## Interface
- `TIMEOUT_W`, default 24: width of the per-SV timeout counter.

- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE
- `abort`  in  1  one-cycle request to terminate the scan; has priority over everything else
- `sv_mask`  in  32  bit n set means search SV n; latched when `start` is accepted
- `threshold`  in  32  unsigned correlation detection threshold; latched when `start` is accepted
- `timeout`  in  TIMEOUT_W  per-SV cycle limit; 0 disables the limit; latched when `start` is accepted
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a completed (non-aborted) scan
- `search_busy`  in  1  coarse search engine busy
- `fine_search_busy`  in  1  fine search engine busy
- `search_start`  out  1  start request to the engine
- `search_sv`  out  5 (`sv_t`)  SV under search
- `search_dop`, `search_code`, `search_corr`  in  32 each  engine results
- `res_valid`  out  1  result record valid
- `res_ready`  in  1  consumer accepts the record
- `res_sv`  out  5  SV of the record
- `res_dop`, `res_code`, `res_corr`  out  32 each  captured results
- `res_found`  out  1  `res_corr >= threshold`, unsigned
- `res_timeout`  out  1  the search for this SV timed out

## Operation
- States: IDLE, SCAN, START, WAIT_FINE, RESULT, FINISH.
- **IDLE:** when `start` is high, latch mask, threshold and timeout, clear the pointer `ptr` to 0, and go to SCAN.
- **SCAN:** examines one mask bit per cycle.
  - `mask[ptr]`=1 → START.
  - Otherwise, `ptr`=31 → FINISH; else `ptr`++ and stay in SCAN.
- **START:**
  - On entry, load the timeout counter.
  - `search_start`=1 and `search_sv`=`ptr` are held until `search_busy`=1 is sampled, then → WAIT_FINE.
  - `search_start` deasserts in the cycle after `search_busy` is sampled high.
- **WAIT_FINE:** completion is a falling edge of `fine_search_busy` (registered previous value =1, current =0). On completion, capture `search_dop`, `search_code`, `search_corr` and go to RESULT.
- **Timeout:**
  - The counter decrements every cycle in START and WAIT_FINE.
  - When it reaches 0 with `timeout`≠0, go to RESULT with `res_timeout`=1, `res_found`=0, and dop/code/corr = 0. `search_start` drops.
- **RESULT:**
  - `res_valid`=1, and all `res_*` fields are held stable until `res_ready`=1.
  - On the handshake: `ptr`=31 → FINISH; else `ptr`++ → SCAN.
- **FINISH:** `done`=1 for one cycle, then → IDLE.
- **Abort:** from any state, the next state is IDLE.
  - `search_start`, `res_valid` and `busy` are 0 the next cycle.
  - No `done` pulse.
  - The engine is not otherwise signalled.
- **Start handling:** `start` outside IDLE is ignored. If `start` and `abort` arrive together in IDLE, the state stays IDLE.
- **Found flag:** 32-bit unsigned compare; equality counts as found.
- **Mask edge cases:** an empty mask produces no records and a `done` pulse. SV 31 is the last index; the pointer never wraps.

## Timing
- **Reset:** state IDLE, `ptr`=0. `busy`, `done`, `search_start`, `res_valid`, `res_found`, `res_timeout` are all 0. `search_sv`=0 and all `res_*` data = 0.
- **All outputs registered:**
  - `start` accepted at edge t → SCAN at t+1.
  - If `mask[0]`=1: `search_start`=1 at t+2.
- **Scan cost:** 1 cycle per skipped index. With an empty mask, `done` is high 33 cycles after the `start` edge.
- **Result latency:** `res_valid` rises in the cycle after the `fine_search_busy` falling edge is sampled.
- **Handshake back-to-back:** `res_valid` drops in the cycle after the handshake, and the next SV's `search_start` can rise one cycle later.
- **Early ready:** `res_ready` high before `res_valid` is legal; the handshake completes on the first `res_valid` cycle.
- **Simultaneous completion and timeout:** the same cycle counts as completion (real results, `res_timeout`=0).

## Structure
- **Shared GNSS types package:** state enum `sched_state_t`, and a `search_result_t` packed struct (sv, dop, code, corr, found, timeout).
- `sv_t` and `word_t` come from the existing packages.
- **Natural sub-module:** `gnss_search_timeout_ctr` (load, enable, zero flag).

## Test plan
- **Two SVs:** mask=0x0000_0021, threshold=100.
  - Engine model returns corr 150 for SV0 and 50 for SV5.
  - Expect two records, SV0 found=1 and SV5 found=0, then one `done`.
- **Empty mask:** mask=0 → no `search_start`, `done` exactly 33 cycles after `start`.
- **Timeout:** timeout=20 with an engine that never asserts `search_busy` → record SV n, `res_timeout`=1, data 0, 20 cycles after START entry.
- **Backpressure:** hold `res_ready`=0 for 10 cycles → `res_*` stable, no new `search_start` until the handshake.
- **Abort:** assert `abort` during WAIT_FINE → IDLE next cycle, `busy`=0, no `done`. A subsequent `start` re-scans from SV0.
- **Reset and start filtering:** reset mid-RESULT → all outputs at reset values next cycle. `start` during a scan is ignored.

Source files
------------

// File: rtl/gnss_search_scheduler_pkg.sv
// Shared types for the GNSS search scheduler.
// This file holds the SV index and data word types, the scheduler state
// encoding, and the captured result record. It also provides the
// detection-threshold helper.
package gnss_search_scheduler_pkg;

  localparam int NUM_SV  = 32;
  localparam int SV_W    = 5;
  localparam int WORD_W  = 32;

  typedef logic [SV_W-1:0]   sv_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam sv_t LAST_SV = sv_t'(NUM_SV - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_FINE = 3'd3,
    ST_RESULT    = 3'd4,
    ST_FINISH    = 3'd5
  } sched_state_t;

  typedef struct packed {
    sv_t   sv;
    word_t dop;
    word_t code;
    word_t corr;
    logic  found;
    logic  timeout;
  } search_result_t;

  // Unsigned detection test; a correlation equal to the threshold is a hit.
  function automatic logic corr_found(input word_t corr, input word_t thr);
    return (corr >= thr);
  endfunction

endpackage

// File: rtl/gnss_search_timeout_ctr.sv
// Per-SV timeout down-counter.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val (takes priority over en)
//   load_val  : value loaded on load
//   en        : decrement by one per cycle; holds at zero
//   zero      : count is zero
module gnss_search_timeout_ctr #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/gnss_search_scheduler.sv
// GNSS acquisition search scheduler.
// The scheduler walks a latched 32-bit SV mask. For each enabled SV it starts
// the search engine and waits for the fine search to finish, or for the
// per-SV timeout to expire. It then captures the result and emits one
// record per SV on a valid/ready stream.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, abort         : scan control (abort has top priority)
//   sv_mask, threshold,
//   timeout              : scan parameters, latched when start is accepted
//   busy, done           : scan status (done is a one-cycle pulse)
//   search_busy,
//   fine_search_busy     : engine status
//   search_start,
//   search_sv            : engine request
//   search_dop/code/corr : engine results
//   res_*                : result record stream
//   dbg_state            : current FSM state
//
// Result stream: a record transfers on a cycle where res_valid and res_ready
// are both high. Once res_valid rises, every res_* field stays constant until
// that transfer. res_ready may be high before res_valid. An abort withdraws
// a pending record.
module gnss_search_scheduler
  import gnss_search_scheduler_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          sv_mask,
  input  logic [31:0]          threshold,
  input  logic [TIMEOUT_W-1:0] timeout,
  output logic                 busy,
  output logic                 done,
  input  logic                 search_busy,
  input  logic                 fine_search_busy,
  output logic                 search_start,
  output sv_t                  search_sv,
  input  word_t                search_dop,
  input  word_t                search_code,
  input  word_t                search_corr,
  output logic                 res_valid,
  input  logic                 res_ready,
  output sv_t                  res_sv,
  output word_t                res_dop,
  output word_t                res_code,
  output word_t                res_corr,
  output logic                 res_found,
  output logic                 res_timeout,
  output sched_state_t         dbg_state
);

  sched_state_t         state_q, state_d;
  sv_t                  ptr_q;
  logic [31:0]          mask_q;
  word_t                thr_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 fine_prev_q;
  search_result_t       result_q;

  logic accept_start;
  logic ptr_inc;
  logic tmo_load;
  logic cap_fine;
  logic cap_tmo;
  logic fine_fall;
  logic tmo_zero;
  logic tmo_expired;
  logic tmo_en;

  assign fine_fall   = fine_prev_q & ~fine_search_busy;
  assign tmo_expired = (tmo_q != '0) && tmo_zero;
  assign tmo_en      = (state_q == ST_START) || (state_q == ST_WAIT_FINE);

  // The counter is loaded with timeout-1 on START entry. Zero is then seen
  // on the timeout-th cycle spent in START/WAIT_FINE. The FSM leaves on that
  // cycle, so exactly `timeout` cycles pass between START entry and RESULT.
  gnss_search_timeout_ctr #(
    .W (TIMEOUT_W)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (tmo_q - TIMEOUT_W'(1)),
    .en       (tmo_en),
    .zero     (tmo_zero)
  );

  // Next-state and control strobes.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    ptr_inc      = 1'b0;
    tmo_load     = 1'b0;
    cap_fine     = 1'b0;
    cap_tmo      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SCAN;
          accept_start = 1'b1;
        end
      end

      ST_SCAN: begin
        if (mask_q[ptr_q]) begin
          state_d  = ST_START;
          tmo_load = 1'b1;
        end else if (ptr_q == LAST_SV) begin
          state_d = ST_FINISH;
        end else begin
          ptr_inc = 1'b1;
        end
      end

      ST_START: begin
        if (tmo_expired) begin
          state_d = ST_RESULT;
          cap_tmo = 1'b1;
        end else if (search_busy) begin
          state_d = ST_WAIT_FINE;
        end
      end

      ST_WAIT_FINE: begin
        // A completion in the same cycle as expiry wins: real data is kept.
        if (fine_fall) begin
          state_d  = ST_RESULT;
          cap_fine = 1'b1;
        end else if (tmo_expired) begin
          state_d = ST_RESULT;
          cap_tmo = 1'b1;
        end
      end

      ST_RESULT: begin
        if (res_ready) begin
          if (ptr_q == LAST_SV) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_SCAN;
            ptr_inc = 1'b1;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      accept_start = 1'b0;
      ptr_inc      = 1'b0;
      tmo_load     = 1'b0;
      cap_fine     = 1'b0;
      cap_tmo      = 1'b0;
    end
  end

  // State, scan context and registered outputs. The status outputs are
  // decoded from state_d, so each one lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      mask_q       <= '0;
      thr_q        <= '0;
      tmo_q        <= '0;
      fine_prev_q  <= 1'b0;
      result_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      search_start <= 1'b0;
      search_sv    <= '0;
      res_valid    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fine_prev_q <= fine_search_busy;

      if (accept_start) begin
        mask_q <= sv_mask;
        thr_q  <= threshold;
        tmo_q  <= timeout;
      end

      if (accept_start) begin
        ptr_q <= '0;
      end else if (ptr_inc) begin
        ptr_q <= ptr_q + sv_t'(1);
      end

      if (tmo_load) begin
        search_sv <= ptr_q;
      end

      if (cap_fine) begin
        result_q <= '{sv: ptr_q, dop: search_dop, code: search_code,
                      corr: search_corr,
                      found: corr_found(search_corr, thr_q),
                      timeout: 1'b0};
      end else if (cap_tmo) begin
        result_q <= '{sv: ptr_q, dop: '0, code: '0, corr: '0,
                      found: 1'b0, timeout: 1'b1};
      end

      busy         <= (state_d != ST_IDLE);
      done         <= (state_d == ST_FINISH);
      search_start <= (state_d == ST_START);
      res_valid    <= (state_d == ST_RESULT);
    end
  end

  assign res_sv      = result_q.sv;
  assign res_dop     = result_q.dop;
  assign res_code    = result_q.code;
  assign res_corr    = result_q.corr;
  assign res_found   = result_q.found;
  assign res_timeout = result_q.timeout;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_gnss_search_scheduler.sv
// Directed testbench for gnss_search_scheduler.
module tb_gnss_search_scheduler;
  import gnss_search_scheduler_pkg::*;

  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   sv_mask = '0;
  logic [31:0]   threshold = '0;
  logic [TW-1:0] timeout = '0;
  logic          busy, done;
  logic          search_busy = 1'b0;
  logic          fine_search_busy = 1'b0;
  logic          search_start;
  sv_t           search_sv;
  word_t         search_dop = '0, search_code = '0, search_corr = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  sv_t           res_sv;
  word_t         res_dop, res_code, res_corr;
  logic          res_found, res_timeout;
  sched_state_t  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;
  int done_count = 0;
  int ss_rises = 0;
  logic ss_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  gnss_search_scheduler #(.TIMEOUT_W(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .sv_mask          (sv_mask),
    .threshold        (threshold),
    .timeout          (timeout),
    .busy             (busy),
    .done             (done),
    .search_busy      (search_busy),
    .fine_search_busy (fine_search_busy),
    .search_start     (search_start),
    .search_sv        (search_sv),
    .search_dop       (search_dop),
    .search_code      (search_code),
    .search_corr      (search_corr),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_sv           (res_sv),
    .res_dop          (res_dop),
    .res_code         (res_code),
    .res_corr         (res_corr),
    .res_found        (res_found),
    .res_timeout      (res_timeout),
    .dbg_state        (dbg_state)
  );

  // Event monitors: handshakes, done pulses and search_start rising edges.
  always @(posedge clk) begin
    if (!rst && res_valid && res_ready) hs_count++;
    if (!rst && done) done_count++;
    if (search_start && !ss_prev) ss_rises++;
    ss_prev = search_start;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 search_start, 1 res_valid, 2 done. n = ticks waited.
  task automatic wait_sig(input int sel, input int max, input string tag, output int n);
    logic s;
    n = 0;
    forever begin
      s = (sel == 0) ? search_start : (sel == 1) ? res_valid : done;
      if (s) break;
      if (n >= max) begin
        chk(tag, 64'(n), 64'(max + 1));
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic begin_scan(input logic [31:0] m, input logic [31:0] thr, input logic [TW-1:0] t);
    sv_mask = m; threshold = thr; timeout = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Engine model: accept the request, run a fine search, then report results.
  task automatic serve(input word_t dop, input word_t code, input word_t corr, input int len);
    int n;
    wait_sig(0, 100, "serve_wait_start", n);
    search_busy = 1'b1;
    tick();
    chk("start_drop", 64'(search_start), 64'(0));
    search_busy = 1'b0;
    fine_search_busy = 1'b1;
    repeat (len) tick();
    search_dop = dop; search_code = code; search_corr = corr;
    fine_search_busy = 1'b0;
    tick();
    chk("res_latency", 64'(res_valid), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int ss0;
    logic stable;
    sv_t s_sv;
    word_t s_dop, s_code, s_corr;
    logic s_found, s_tmo;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_search_start", 64'(search_start), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Two SVs: SV0 detected, SV5 not; backpressure on SV0.
    begin_scan(32'h0000_0021, 32'd100, '0);
    chk("t1_busy", 64'(busy), 64'(1));
    serve(32'h1111, 32'h2222, 32'd150, 3);
    chk("t1_sv0_sv", 64'(res_sv), 64'(0));
    chk("t1_sv0_found", 64'(res_found), 64'(1));
    chk("t1_sv0_corr", 64'(res_corr), 64'd150);
    chk("t1_sv0_dop", 64'(res_dop), 64'h1111);
    chk("t1_sv0_code", 64'(res_code), 64'h2222);
    chk("t1_sv0_tmo", 64'(res_timeout), 64'(0));
    s_sv = res_sv; s_dop = res_dop; s_code = res_code; s_corr = res_corr;
    s_found = res_found; s_tmo = res_timeout;
    ss0 = ss_rises;
    stable = 1'b1;
    search_dop = 32'hdead; search_corr = 32'd7;
    repeat (10) begin
      tick();
      stable &= res_valid && (res_sv == s_sv) && (res_dop == s_dop) && (res_code == s_code)
                && (res_corr == s_corr) && (res_found == s_found) && (res_timeout == s_tmo);
    end
    chk("bp_stable", 64'(stable), 64'(1));
    chk("bp_no_start", 64'(ss_rises - ss0), 64'(0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_valid_drop", 64'(res_valid), 64'(0));
    wait_sig(0, 50, "t1_wait_sv5", n);
    chk("t1_scan_cost", 64'(n), 64'(5));
    chk("t1_search_sv5", 64'(search_sv), 64'(5));
    res_ready = 1'b1;  // early ready
    serve(32'h3333, 32'h4444, 32'd50, 2);
    chk("t1_sv5_sv", 64'(res_sv), 64'(5));
    chk("t1_sv5_found", 64'(res_found), 64'(0));
    chk("t1_sv5_corr", 64'(res_corr), 64'd50);
    tick();
    chk("t1_early_ready_drop", 64'(res_valid), 64'(0));
    res_ready = 1'b0;
    wait_sig(2, 100, "t1_wait_done", n);
    tick();
    chk("t1_done_pulse", 64'(done), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_records", 64'(hs_count), 64'(2));
    chk("t1_done_count", 64'(done_count), 64'(1));

    // Empty mask: no engine start, done 33 cycles after start edge.
    ss0 = ss_rises;
    begin_scan(32'h0, 32'd0, '0);
    wait_sig(2, 60, "t2_wait_done", n);
    chk("t2_done_latency", 64'(n + 1), 64'(33));
    chk("t2_no_start", 64'(ss_rises - ss0), 64'(0));
    chk("t2_no_record", 64'(hs_count), 64'(2));

    // Abort during WAIT_FINE; start inside a scan is ignored.
    tick();
    begin_scan(32'h0000_0003, 32'd77, '0);
    wait_sig(0, 20, "t3_wait_start", n);
    search_busy = 1'b1;
    tick();
    search_busy = 1'b0;
    fine_search_busy = 1'b1;
    tick();
    sv_mask = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_start_ignored", 64'(dbg_state), 64'(ST_WAIT_FINE));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    fine_search_busy = 1'b0;
    chk("t3_abort_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("t3_abort_busy", 64'(busy), 64'(0));
    chk("t3_abort_sstart", 64'(search_start), 64'(0));
    chk("t3_abort_valid", 64'(res_valid), 64'(0));
    repeat (5) tick();
    chk("t3_no_done", 64'(done_count), 64'(2));

    // Rescan from SV0; equality counts as found; reset mid-RESULT.
    begin_scan(32'h0000_0003, 32'd77, '0);
    chk("t4_t1_sstart", 64'(search_start), 64'(0));
    tick();
    chk("t4_t2_sstart", 64'(search_start), 64'(1));
    chk("t4_rescan_sv0", 64'(search_sv), 64'(0));
    serve(32'h5, 32'h6, 32'd77, 1);
    chk("t4_eq_found", 64'(res_found), 64'(1));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    serve(32'h7, 32'h8, 32'd200, 2);
    chk("t4_sv1_sv", 64'(res_sv), 64'(1));
    chk("t4_sv1_found", 64'(res_found), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_valid", 64'(res_valid), 64'(0));
    chk("t4_rst_busy", 64'(busy), 64'(0));
    chk("t4_rst_found", 64'(res_found), 64'(0));
    chk("t4_rst_sv", 64'(res_sv), 64'(0));
    chk("t4_rst_corr", 64'(res_corr), 64'(0));
    chk("t4_rst_dop", 64'(res_dop), 64'(0));
    chk("t4_rst_search_sv", 64'(search_sv), 64'(0));
    chk("t4_rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Timeout: engine never responds; threshold 0 must still report not found.
    search_corr = 32'd999;
    begin_scan(32'h0000_0100, 32'd0, TW'(20));
    wait_sig(0, 40, "t5_wait_start", n);
    chk("t5_search_sv", 64'(search_sv), 64'(8));
    wait_sig(1, 60, "t5_wait_result", n);
    chk("t5_timeout_latency", 64'(n), 64'(20));
    chk("t5_tmo_flag", 64'(res_timeout), 64'(1));
    chk("t5_tmo_sv", 64'(res_sv), 64'(8));
    chk("t5_tmo_found", 64'(res_found), 64'(0));
    chk("t5_tmo_corr", 64'(res_corr), 64'(0));
    chk("t5_tmo_sstart", 64'(search_start), 64'(0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    wait_sig(2, 60, "t5_wait_done", n);
    chk("t5_done", 64'(done), 64'(1));

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
